// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, fetches one instruction at a time over a ready-based
// imem handshake, holds it for the control unit and steers the PC on acknowledge.
module fetch_pc_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic            inst_valid,
    input  logic            inst_ack,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic            bcond,
    input  logic            is_halted,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            halted,
    output logic [31:0]     retired_cnt
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK = ~(XLEN'(1));

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic            r_halted;
    logic [31:0]     r_retired_cnt;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_next_pc;
    logic            w_fetch_done;
    logic            w_retire;

    assign w_pc_plus4 = r_pc + PC_STEP;
    assign w_pc_rel   = r_pc + imm;
    assign w_jalr_tgt = (rs1_data + imm) & JALR_MASK;

    assign w_fetch_done = (r_state == ST_FETCH) && imem_ready;
    assign w_retire     = (r_state == ST_EXEC) && inst_ack;

    // Next-PC select; jalr outranks jal, which outranks a taken branch.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (is_jalr) begin
            w_next_pc = w_jalr_tgt;
        end else if (is_jal) begin
            w_next_pc = w_pc_rel;
        end else if (branch && bcond) begin
            w_next_pc = w_pc_rel;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    // Fetch/exec/halt sequencing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (inst_ack && is_halted) begin
                    w_state_nxt = ST_HALT;
                end else if (inst_ack) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction register captures only on a completed fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst <= 32'd0;
        end else if (w_fetch_done) begin
            r_inst <= imem_rdata;
        end else begin
            r_inst <= r_inst;
        end
    end

    // PC and retirement counter advance together on acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_retired_cnt <= 32'd0;
        end else if (w_retire) begin
            r_pc          <= w_next_pc;
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end else begin
            r_pc          <= r_pc;
            r_retired_cnt <= r_retired_cnt;
        end
    end

    // Sticky halt flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halted <= 1'b0;
        end else if (w_retire && is_halted) begin
            r_halted <= 1'b1;
        end else begin
            r_halted <= r_halted;
        end
    end

    // Request is gated by reset so it drops at once when reset asserts mid-fetch.
    assign imem_req    = (r_state == ST_FETCH) && reset;
    assign imem_addr   = r_pc;
    assign inst        = r_inst;
    assign inst_valid  = (r_state == ST_EXEC);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign halted      = r_halted;
    assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: handshake, next-PC selection, wrap, halt and
// asynchronous reset, all against hand-computed expectations.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ack;
    logic        is_jal;
    logic        is_jalr;
    logic        branch;
    logic        bcond;
    logic        is_halted;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [31:0] retired_cnt;

    int n_checks;
    int n_fail;
    int exp_retired;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack),
        .is_jal(is_jal), .is_jalr(is_jalr), .branch(branch), .bcond(bcond),
        .is_halted(is_halted), .imm(imm), .rs1_data(rs1_data),
        .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_ctrl();
        inst_ack  = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; branch = 1'b0;
        bcond     = 1'b0; is_halted = 1'b0; imm = 32'd0; rs1_data = 32'd0;
    endtask

    // Called #1 after a rising edge while in FETCH; completes the fetch in one edge.
    task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        check_val({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check_val({tag, "_addr"}, imem_addr, exp_addr);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_val({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check_val({tag, "_inst"}, inst, word);
        check_val({tag, "_req_exec"}, {31'd0, imem_req}, 32'd0);
    endtask

    // Called #1 after a rising edge while in EXEC; acknowledges with the given controls.
    task automatic do_ack(input string tag, input logic jal, input logic jalr, input logic br,
                          input logic bc, input logic hlt, input logic [31:0] imm_v,
                          input logic [31:0] rs1_v, input logic [31:0] exp_pc);
        inst_ack = 1'b1; is_jal = jal; is_jalr = jalr; branch = br; bcond = bc;
        is_halted = hlt; imm = imm_v; rs1_data = rs1_v;
        @(posedge clk); #1;
        clear_ctrl();
        exp_retired++;
        check_val({tag, "_pc"}, pc, exp_pc);
        check_val({tag, "_cnt"}, retired_cnt, exp_retired);
        check_val({tag, "_valid_drop"}, {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_retired = 0;
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
        clear_ctrl();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_inst", inst, 32'h0);
        check_val("rst_cnt", retired_cnt, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rel_req", {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        // That edge had imem_ready low, so still fetching at 0; ack in FETCH is ignored.
        inst_ack = 1'b1;
        @(posedge clk); #1;
        inst_ack = 1'b0;
        check_val("ack_in_fetch_pc", pc, 32'h0);
        check_val("ack_in_fetch_cnt", retired_cnt, 32'd0);

        // Sequential addi stream.
        do_fetch("s0", 32'h0, 32'h0010_0093);
        // imem_ready in EXEC must not disturb the held instruction.
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        check_val("ready_in_exec_inst", inst, 32'h0010_0093);
        check_val("ready_in_exec_valid", {31'd0, inst_valid}, 32'd1);
        do_ack("s0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h4);
        do_fetch("s1", 32'h4, 32'h0020_0113);
        do_ack("s1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h8);
        do_fetch("s2", 32'h8, 32'h0030_0193);
        do_ack("s2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hC);
        check_val("three_retired", retired_cnt, 32'd3);

        // Stalled fetch: request and address hold while imem_ready is low.
        for (int i = 0; i < 5; i++) begin
            check_val("stall_req", {31'd0, imem_req}, 32'd1);
            check_val("stall_addr", imem_addr, 32'hC);
            check_val("stall_valid", {31'd0, inst_valid}, 32'd0);
            @(posedge clk); #1;
        end
        do_fetch("stall", 32'hC, 32'h0040_0213);
        do_ack("stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h10);

        // Jumps.
        do_fetch("jal", 32'h10, 32'hFF9F_F0EF);
        do_ack("jal", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0, 32'h08);
        do_fetch("jalr", 32'h08, 32'h0020_80E7);
        do_ack("jalr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2, 32'h101, 32'h102);
        check_val("pc_plus4_102", pc_plus4, 32'h106);
        do_fetch("jal_back", 32'h102, 32'h0000_006F);
        do_ack("jal_back", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF1E, 32'd0, 32'h20);

        // Branches.
        do_fetch("br_nt", 32'h20, 32'h0000_0063);
        do_ack("br_nt", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 32'h24);
        do_fetch("jal_m4", 32'h24, 32'h0000_006F);
        do_ack("jal_m4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'h20);
        do_fetch("br_t", 32'h20, 32'h0400_0063);
        do_ack("br_t", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 32'h60);

        // jalr outranks jal; bit 0 cleared; then wrap past the top of memory.
        do_fetch("prio", 32'h60, 32'h0000_0067);
        do_ack("prio", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB, 32'hFFFF_FFF0, 32'hFFFF_FFFA);
        do_fetch("to_top", 32'hFFFF_FFFA, 32'h0000_006F);
        do_ack("to_top", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2, 32'd0, 32'hFFFF_FFFC);
        check_val("pc_plus4_wrap", pc_plus4, 32'h0);
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0013);
        do_ack("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0);
        do_fetch("to_30", 32'h0, 32'h0000_006F);
        do_ack("to_30", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30, 32'd0, 32'h30);

        // Halt on ecall.
        do_fetch("ecall", 32'h30, 32'h0000_0073);
        do_ack("ecall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h34);
        check_val("halted_set", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            imem_ready = i[0];
            inst_ack   = ~i[0];
            is_jal     = 1'b1;
            imm        = 32'h100;
            @(posedge clk); #1;
            check_val("halt_req", {31'd0, imem_req}, 32'd0);
            check_val("halt_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ready = 1'b0;
        clear_ctrl();
        check_val("halt_cnt", retired_cnt, 32'd15);
        check_val("halt_pc", pc, 32'h34);
        check_val("halt_sticky", {31'd0, halted}, 32'd1);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_retired = 0;
        @(posedge clk); #1;
        do_fetch("rs_f", 32'h0, 32'h0000_0093);
        #3;
        reset = 1'b0;
        #1;
        check_val("async_valid", {31'd0, inst_valid}, 32'd0);
        check_val("async_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rerel_pc", pc, 32'h0);
        check_val("rerel_cnt", retired_cnt, 32'd0);
        check_val("rerel_halted", {31'd0, halted}, 32'd0);
        check_val("rerel_inst", inst, 32'd0);
        @(posedge clk); #1;
        do_fetch("restart", 32'h0, 32'h0050_0293);
        do_ack("restart", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
